// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller.
package hazard_pkg;

  // E-stage operand mux selects
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  // Data-memory wait-state controller
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones, synchronous clear.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: advance on event unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + WIDTH'(1);
  end

  // Count register with synchronous clear
  always_ff @(posedge clk_i) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage RV32I pipeline: operand forwarding,
// load-use / RAW stalls, branch flush, data-memory wait states with timeout,
// and saturating stall/flush event counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned FWD_EN      = 1,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic              reg_write_e,
  input  logic              result_src_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic              pc_src_e,
  input  logic              mem_req_m,
  input  logic              mem_ready_m,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_w,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned    WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_err_q, mem_err_d;

  logic e_hit, m_hit, raw_stall, mem_hold, branch, load_use;

  // Operand forwarding: M-stage result has priority over W; x0 never forwarded
  always_comb begin
    forward_a_e = FWD_REG;
    forward_b_e = FWD_REG;
    if ((FWD_EN != 0) && !rst) begin
      if (reg_write_m && (rd_m != '0) && (rd_m == rs1_e))      forward_a_e = FWD_M;
      else if (reg_write_w && (rd_w != '0) && (rd_w == rs1_e)) forward_a_e = FWD_W;
      if (reg_write_m && (rd_m != '0) && (rd_m == rs2_e))      forward_b_e = FWD_M;
      else if (reg_write_w && (rd_w != '0) && (rd_w == rs2_e)) forward_b_e = FWD_W;
    end
  end

  // Hazard detection and stage-register control
  always_comb begin
    e_hit = reg_write_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    m_hit = reg_write_m && (rd_m != '0) && ((rd_m == rs1_d) || (rd_m == rs2_d));
    // Without forwarding any in-flight E/M producer must drain first;
    // W producers are covered by write-before-read in the register file.
    raw_stall = (FWD_EN != 0) ? (e_hit && result_src_e) : (e_hit || m_hit);
    // A miss freezes the pipeline in the same cycle it is seen, not only
    // once the FSM has moved to MEM_WAIT.
    mem_hold  = (state_q == RUN) ? (mem_req_m && !mem_ready_m) : 1'b1;
    branch    = pc_src_e && !mem_hold;
    load_use  = raw_stall && !mem_hold && !pc_src_e;

    stall_f = !rst && (mem_hold || load_use);
    stall_d = !rst && (mem_hold || load_use);
    stall_e = !rst && mem_hold;
    stall_m = !rst && mem_hold;
    flush_d = !rst && branch;
    flush_e = !rst && (branch || load_use);
    flush_w = !rst && mem_hold;
  end

  // Wait-state FSM next-state, wait counter and sticky error
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_err_d = mem_err_q;
    case (state_q)
      RUN: begin
        wait_d = '0;
        if (mem_req_m && !mem_ready_m) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_ready_m) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d   = MEM_ERR;
          mem_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      MEM_ERR: mem_err_d = 1'b1;
      default: state_d = RUN;
    endcase
  end

  // FSM state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk_i (clk),
    .clr_i (rst),
    .inc_i (stall_f),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk_i (clk),
    .clr_i (rst),
    .inc_i (flush_d),
    .cnt_o (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: a forwarding instance (MEM_TIMEOUT=4) and a
// stall-only instance (CNT_W=4) share the same stimulus.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       reg_write_e, result_src_e, reg_write_m, reg_write_w;
  logic       pc_src_e, mem_req_m, mem_ready_m;

  logic [1:0]  fa0, fb0, fa1, fb1;
  logic        sf0, sd0, se0, sm0, fd0, fe0, fw0, err0;
  logic        sf1, sd1, se1, sm1, fd1, fe1, fw1, err1;
  logic [31:0] scnt0, fcnt0;
  logic [3:0]  scnt1, fcnt1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_AW(5), .FWD_EN(1), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .reg_write_e(reg_write_e), .result_src_e(result_src_e),
    .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .pc_src_e(pc_src_e), .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
    .forward_a_e(fa0), .forward_b_e(fb0), .stall_f(sf0), .stall_d(sd0),
    .stall_e(se0), .stall_m(sm0), .flush_d(fd0), .flush_e(fe0), .flush_w(fw0),
    .mem_err(err0), .stall_cnt(scnt0), .flush_cnt(fcnt0)
  );

  hazard_ctrl_unit #(.REG_AW(5), .FWD_EN(0), .MEM_TIMEOUT(16), .CNT_W(4)) dut_nf (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .reg_write_e(reg_write_e), .result_src_e(result_src_e),
    .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .pc_src_e(pc_src_e), .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
    .forward_a_e(fa1), .forward_b_e(fb1), .stall_f(sf1), .stall_d(sd1),
    .stall_e(se1), .stall_m(sm1), .flush_d(fd1), .flush_e(fe1), .flush_w(fw1),
    .mem_err(err1), .stall_cnt(scnt1), .flush_cnt(fcnt1)
  );

  typedef struct {
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
    logic       rw_e, ld_e;
    logic [4:0] rd_m;
    logic       rw_m;
    logic [4:0] rd_w;
    logic       rw_w, pc;
    logic [1:0] fa, fb;      // forwarding instance expectations
    logic       st, fd, fe;
    logic       nst, nfd, nfe; // stall-only instance expectations
  } vec_t;

  vec_t tab[12];
  vec_t sb[$];
  vec_t zv;
  vec_t e;

  function automatic vec_t mk(
    input logic [4:0] a_rs1_d, a_rs2_d, a_rs1_e, a_rs2_e, a_rd_e,
    input logic a_rw_e, a_ld_e, input logic [4:0] a_rd_m, input logic a_rw_m,
    input logic [4:0] a_rd_w, input logic a_rw_w, a_pc,
    input logic [1:0] a_fa, a_fb, input logic a_st, a_fd, a_fe, a_nst, a_nfd, a_nfe);
    vec_t v;
    v.rs1_d = a_rs1_d; v.rs2_d = a_rs2_d; v.rs1_e = a_rs1_e; v.rs2_e = a_rs2_e;
    v.rd_e = a_rd_e; v.rw_e = a_rw_e; v.ld_e = a_ld_e; v.rd_m = a_rd_m; v.rw_m = a_rw_m;
    v.rd_w = a_rd_w; v.rw_w = a_rw_w; v.pc = a_pc; v.fa = a_fa; v.fb = a_fb;
    v.st = a_st; v.fd = a_fd; v.fe = a_fe; v.nst = a_nst; v.nfd = a_nfd; v.nfe = a_nfe;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rs1_d = v.rs1_d; rs2_d = v.rs2_d; rs1_e = v.rs1_e; rs2_e = v.rs2_e;
    rd_e = v.rd_e; reg_write_e = v.rw_e; result_src_e = v.ld_e;
    rd_m = v.rd_m; reg_write_m = v.rw_m; rd_w = v.rd_w; reg_write_w = v.rw_w;
    pc_src_e = v.pc;
  endtask

  // Advance to the next cycle and apply stimulus shortly after the edge
  task automatic step(input vec_t v, input logic req, input logic rdy);
    @(posedge clk); #1;
    drive(v); mem_req_m = req; mem_ready_m = rdy;
  endtask

  task automatic chk_frozen(input string nm, input logic exp);
    chk({nm, " stall_f"}, 32'(sf0), 32'(exp));
    chk({nm, " stall_d"}, 32'(sd0), 32'(exp));
    chk({nm, " stall_e"}, 32'(se0), 32'(exp));
    chk({nm, " stall_m"}, 32'(sm0), 32'(exp));
    chk({nm, " flush_w"}, 32'(fw0), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    zv = mk(0,0,0,0,0, 0,0, 0,0, 0,0, 0, 2'b00,2'b00, 0,0,0, 0,0,0);
    //        rs1d rs2d rs1e rs2e rde we ld rdm wm rdw ww pc  fa    fb   st fd fe  nst nfd nfe
    tab[0]  = mk(0, 0, 5, 0, 0, 0,0, 5,1, 5,1, 0, 2'b10,2'b00, 0,0,0, 0,0,0);
    tab[1]  = mk(0, 0, 5, 0, 0, 0,0, 0,1, 5,1, 0, 2'b01,2'b00, 0,0,0, 0,0,0);
    tab[2]  = mk(0, 0, 0, 9, 0, 0,0, 9,0, 9,1, 0, 2'b00,2'b01, 0,0,0, 0,0,0);
    tab[3]  = mk(0, 0, 4, 4, 0, 0,0, 4,1, 0,0, 0, 2'b10,2'b10, 0,0,0, 0,0,0);
    tab[4]  = mk(0, 0, 0, 0, 0, 0,0, 0,0, 0,1, 0, 2'b00,2'b00, 0,0,0, 0,0,0);
    tab[5]  = mk(0, 3, 0, 0, 3, 1,1, 0,0, 0,0, 0, 2'b00,2'b00, 1,0,1, 1,0,1);
    tab[6]  = mk(0, 0, 0, 0, 0, 1,1, 0,0, 0,0, 0, 2'b00,2'b00, 0,0,0, 0,0,0);
    tab[7]  = mk(6, 0, 0, 0, 6, 1,0, 0,0, 0,0, 0, 2'b00,2'b00, 0,0,0, 1,0,1);
    tab[8]  = mk(8, 0, 0, 0, 8, 0,1, 0,0, 0,0, 0, 2'b00,2'b00, 0,0,0, 0,0,0);
    tab[9]  = mk(3, 0, 0, 0, 3, 1,1, 0,0, 0,0, 1, 2'b00,2'b00, 0,1,1, 0,1,1);
    tab[10] = mk(7, 0, 0, 0, 0, 0,0, 0,0, 7,1, 0, 2'b00,2'b00, 0,0,0, 0,0,0);
    tab[11] = mk(7, 0, 0, 0, 0, 0,0, 7,1, 0,0, 0, 2'b00,2'b00, 0,0,0, 1,0,1);

    // Reset with hazards present on the inputs: every control output low
    rst = 1'b1; mem_req_m = 1'b0; mem_ready_m = 1'b0;
    drive(tab[9]);
    rd_m = 5'd5; reg_write_m = 1'b1; rs1_e = 5'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst forward_a", 32'(fa0), 32'h0);
    chk("rst stall_f", 32'(sf0), 32'h0);
    chk("rst flush_d", 32'(fd0), 32'h0);
    chk("rst flush_e", 32'(fe0), 32'h0);
    chk("rst nf stall_f", 32'(sf1), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; drive(zv);
    @(negedge clk);
    chk("post-rst stall_cnt", scnt0, 32'h0);
    chk("post-rst flush_cnt", fcnt0, 32'h0);
    chk("post-rst mem_err", 32'(err0), 32'h0);
    chk("post-rst stall_f", 32'(sf0), 32'h0);

    // Table vectors through the scoreboard
    for (int i = 0; i < 12; i++) begin
      step(tab[i], 1'b0, 1'b0);
      sb.push_back(tab[i]);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("v%0d forward_a", i), 32'(fa0), 32'(e.fa));
      chk($sformatf("v%0d forward_b", i), 32'(fb0), 32'(e.fb));
      chk($sformatf("v%0d stall_f", i), 32'(sf0), 32'(e.st));
      chk($sformatf("v%0d stall_d", i), 32'(sd0), 32'(e.st));
      chk($sformatf("v%0d stall_e", i), 32'(se0), 32'h0);
      chk($sformatf("v%0d flush_d", i), 32'(fd0), 32'(e.fd));
      chk($sformatf("v%0d flush_e", i), 32'(fe0), 32'(e.fe));
      chk($sformatf("v%0d flush_w", i), 32'(fw0), 32'h0);
      chk($sformatf("v%0d nf forward_a", i), 32'(fa1), 32'h0);
      chk($sformatf("v%0d nf forward_b", i), 32'(fb1), 32'h0);
      chk($sformatf("v%0d nf stall_f", i), 32'(sf1), 32'(e.nst));
      chk($sformatf("v%0d nf flush_d", i), 32'(fd1), 32'(e.nfd));
      chk($sformatf("v%0d nf flush_e", i), 32'(fe1), 32'(e.nfe));
    end
    step(zv, 1'b0, 1'b0);
    @(negedge clk);
    chk("table stall_cnt", scnt0, 32'd1);
    chk("table flush_cnt", fcnt0, 32'd1);
    chk("table nf stall_cnt", 32'(scnt1), 32'd3);
    chk("table nf flush_cnt", 32'(fcnt1), 32'd1);

    // Memory miss for three cycles with branch + load-use pending: frozen 4 cycles
    for (int c = 0; c < 4; c++) begin
      step(tab[9], 1'b1, (c == 3));
      @(negedge clk);
      chk_frozen($sformatf("wait c%0d", c), 1'b1);
      chk($sformatf("wait c%0d flush_d", c), 32'(fd0), 32'h0);
      chk($sformatf("wait c%0d flush_e", c), 32'(fe0), 32'h0);
      chk($sformatf("wait c%0d nf stall_m", c), 32'(sm1), 32'h1);
    end
    step(tab[9], 1'b0, 1'b1);
    @(negedge clk);
    chk_frozen("resume", 1'b0);
    chk("resume flush_d", 32'(fd0), 32'h1);
    chk("resume flush_e", 32'(fe0), 32'h1);
    chk("wait stall_cnt", scnt0, 32'd5);
    chk("wait flush_cnt", fcnt0, 32'd1);
    chk("wait nf stall_cnt", 32'(scnt1), 32'd7);
    step(zv, 1'b0, 1'b0);
    @(negedge clk);
    chk("resume flush_cnt", fcnt0, 32'd2);
    chk("resume nf flush_cnt", 32'(fcnt1), 32'd2);

    // Single-cycle access never stalls
    step(zv, 1'b1, 1'b1);
    @(negedge clk);
    chk_frozen("1cyc", 1'b0);

    // Timeout: error appears once MEM_TIMEOUT wait cycles have elapsed
    for (int k = 0; k < 6; k++) begin
      step(zv, 1'b1, 1'b0);
      @(negedge clk);
      chk($sformatf("tmo k%0d mem_err", k), 32'(err0), 32'((k == 5) ? 1 : 0));
      chk($sformatf("tmo k%0d stall_f", k), 32'(sf0), 32'h1);
      chk($sformatf("tmo k%0d nf mem_err", k), 32'(err1), 32'h0);
    end
    // Error is sticky even when memory answers; stall-only instance releases
    for (int k = 6; k < 8; k++) begin
      step(zv, 1'b0, 1'b1);
      @(negedge clk);
      chk($sformatf("sticky k%0d mem_err", k), 32'(err0), 32'h1);
      chk_frozen($sformatf("sticky k%0d", k), 1'b1);
      chk($sformatf("sticky k%0d nf stall_f", k), 32'(sf1), 32'((k == 6) ? 1 : 0));
    end
    // New miss on the stall-only instance, then reset while it waits
    for (int k = 0; k < 2; k++) begin
      step(zv, 1'b1, 1'b0);
      @(negedge clk);
      chk($sformatf("miss2 k%0d nf stall_f", k), 32'(sf1), 32'h1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst2 stall_f", 32'(sf0), 32'h0);
    chk("rst2 flush_w", 32'(fw0), 32'h0);
    chk("rst2 nf stall_f", 32'(sf1), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; mem_req_m = 1'b0; mem_ready_m = 1'b0;
    @(negedge clk);
    chk("rst2 mem_err", 32'(err0), 32'h0);
    chk("rst2 run stall_f", 32'(sf0), 32'h0);
    chk("rst2 nf run stall_f", 32'(sf1), 32'h0);
    chk("rst2 stall_cnt", scnt0, 32'h0);
    chk("rst2 flush_cnt", fcnt0, 32'h0);
    chk("rst2 nf stall_cnt", 32'(scnt1), 32'h0);

    // Stall-only RAW stall every cycle: 4-bit counter saturates at 15
    for (int j = 0; j < 20; j++) begin
      step(tab[7], 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("sat j%0d nf stall_cnt", j), 32'(scnt1), 32'((j < 15) ? j : 15));
    end
    chk("sat fwd stall_cnt", scnt0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
